// File: rtl/issue_buffer.sv
// rtl/issue_buffer.sv - in-order dual-issue instruction queue between decode and issue
package issue_pkg;
    typedef struct packed {
        logic        o_valid;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic [3:0]  ldst_type;
        logic [3:0]  br_type;
    } PC_set;
endpackage

module issue_buffer
    import issue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  PC_set            d_set1,
    input  PC_set            d_set2,
    input  logic             d_valid1,
    input  logic             d_valid2,
    output logic             d_ready,
    input  logic             flush_BR,
    input  logic             stall_DCache,
    output PC_set            i_set1,
    output PC_set            i_set2,
    output logic [1:0]       issue_cnt,
    output logic [PTR_W:0]   buf_cnt
);

    localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 2);

    PC_set            mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nxt1;
    logic [PTR_W-1:0] tail_nxt1;
    logic [PTR_W:0]   count;
    PC_set            ent_a;
    PC_set            ent_b;
    logic             v_a;
    logic             v_b;
    logic             raw;
    logic             both_mem;
    logic             pair_ok;
    logic             enq_en;
    logic [1:0]       enq_cnt;

    assign head_nxt1 = head + 1'b1;
    assign tail_nxt1 = tail + 1'b1;
    assign ent_a     = mem[head];
    assign ent_b     = mem[head_nxt1];

    // Readiness looks only at registered occupancy so the decoder sees no path from issue.
    assign d_ready = (count <= READY_MAX);
    assign buf_cnt = count;

    assign raw = ent_a.rf_we && (ent_a.rf_rd != 5'd0) &&
                 ((ent_b.rf_raddr1 == ent_a.rf_rd) || (ent_b.rf_raddr2 == ent_a.rf_rd));
    assign both_mem = ent_a.ldst_type[3] && ent_b.ldst_type[3];
    assign pair_ok  = !raw && !both_mem && (ent_a.br_type == 4'd0);

    assign v_a = (count != '0);
    assign v_b = (count > (PTR_W + 1)'(1)) && v_a && pair_ok;

    always_comb begin
        i_set1 = '0;
        i_set2 = '0;
        if (v_a) begin
            i_set1         = ent_a;
            i_set1.o_valid = 1'b1;
        end
        if (v_b) begin
            i_set2         = ent_b;
            i_set2.o_valid = 1'b1;
        end
    end

    assign issue_cnt = (stall_DCache || flush_BR) ? 2'd0 : (2'(v_a) + 2'(v_b));

    assign enq_en  = d_ready && !flush_BR;
    assign enq_cnt = enq_en ? (2'(d_valid1) + 2'(d_valid2)) : 2'd0;

    always_ff @(posedge clk) begin
        if (enq_en && d_valid1) begin
            mem[tail] <= d_set1;
        end
        if (enq_en && d_valid2) begin
            mem[tail_nxt1] <= d_set2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_BR) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(issue_cnt);
            tail  <= tail + PTR_W'(enq_cnt);
            count <= count + (PTR_W + 1)'(enq_cnt) - (PTR_W + 1)'(issue_cnt);
        end
    end

endmodule

// File: tb/tb_issue_buffer.sv
// tb/tb_issue_buffer.sv - directed bench for issue_buffer against a queue model
module tb_issue_buffer;
    import issue_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    PC_set      d_set1 = '0;
    PC_set      d_set2 = '0;
    logic       d_valid1 = 1'b0;
    logic       d_valid2 = 1'b0;
    logic       flush_BR = 1'b0;
    logic       stall_DCache = 1'b0;
    logic       d_ready;
    PC_set      i_set1;
    PC_set      i_set2;
    logic [1:0] issue_cnt;
    logic [3:0] buf_cnt;

    int vectors = 0;
    int errors  = 0;

    PC_set q[$];

    issue_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .d_set1(d_set1), .d_set2(d_set2),
        .d_valid1(d_valid1), .d_valid2(d_valid2),
        .d_ready(d_ready),
        .flush_BR(flush_BR), .stall_DCache(stall_DCache),
        .i_set1(i_set1), .i_set2(i_set2),
        .issue_cnt(issue_cnt), .buf_cnt(buf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic PC_set mk(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [3:0] ldst, input logic [3:0] br);
        PC_set e;
        e           = '0;
        e.pc        = pc;
        e.rf_rd     = rd;
        e.rf_we     = we;
        e.rf_raddr1 = r1;
        e.rf_raddr2 = r2;
        e.ldst_type = ldst;
        e.br_type   = br;
        return e;
    endfunction

    function automatic PC_set ind(input logic [31:0] pc);
        return mk(pc, 5'd1, 1'b0, 5'd2, 5'd3, 4'd0, 4'd0);
    endfunction

    // Model: an ordered list of waiting instructions; the front two are the issue candidates.
    function automatic logic m_pair(input PC_set a, input PC_set b);
        logic hazard;
        hazard = a.rf_we && (a.rf_rd != 5'd0) &&
                 ((b.rf_raddr1 == a.rf_rd) || (b.rf_raddr2 == a.rf_rd));
        return !hazard && !(a.ldst_type[3] && b.ldst_type[3]) && (a.br_type == 4'd0);
    endfunction

    function automatic logic m_va();
        return q.size() >= 1;
    endfunction

    function automatic logic m_vb();
        if (q.size() < 2) return 1'b0;
        return m_pair(q[0], q[1]);
    endfunction

    function automatic int m_issue();
        if (stall_DCache || flush_BR) return 0;
        return int'(m_va()) + int'(m_vb());
    endfunction

    function automatic PC_set m_slot(input int idx);
        PC_set e;
        e = '0;
        if ((idx == 0 && m_va()) || (idx == 1 && m_vb())) begin
            e         = q[idx];
            e.o_valid = 1'b1;
        end
        return e;
    endfunction

    initial begin : model
        int  n;
        bit  rdy;
        forever begin
            @(posedge clk or posedge rst);
            if (rst || flush_BR) begin
                q.delete();
            end else begin
                n   = m_issue();
                rdy = (q.size() <= DEPTH - 2);
                repeat (n) void'(q.pop_front());
                if (rdy && d_valid1) q.push_back(d_set1);
                if (rdy && d_valid2) q.push_back(d_set2);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("d_ready",   64'(d_ready),   64'(q.size() <= DEPTH - 2));
                chk("buf_cnt",   64'(buf_cnt),   64'(q.size()));
                chk("issue_cnt", 64'(issue_cnt), 64'(m_issue()));
                chk("i_set1",    64'(i_set1),    64'(m_slot(0)));
                chk("i_set2",    64'(i_set2),    64'(m_slot(1)));
            end
        end
    end

    task automatic step(input PC_set a, input PC_set b, input logic v1, input logic v2,
                        input logic st, input logic fl);
        @(posedge clk);
        #1;
        d_set1       = a;
        d_set2       = b;
        d_valid1     = v1;
        d_valid2     = v2;
        stall_DCache = st;
        flush_BR     = fl;
        #2;
    endtask

    task automatic idle(input logic st);
        step('0, '0, 1'b0, 1'b0, st, 1'b0);
    endtask

    initial begin : stim
        PC_set a;
        PC_set b;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_buf_cnt", 64'(buf_cnt), 64'd0);
        chk("rst_d_ready", 64'(d_ready), 64'd1);
        chk("rst_issue",   64'(issue_cnt), 64'd0);
        chk("rst_set1",    64'(i_set1), 64'd0);
        chk("rst_set2",    64'(i_set2), 64'd0);

        // asynchronous reset with five entries waiting
        step(ind(32'd1), ind(32'd2), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd3), ind(32'd4), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd5), '0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        chk("pre_rst_cnt", 64'(buf_cnt), 64'd5);
        rst = 1'b1;
        stall_DCache = 1'b0;
        d_valid1 = 1'b0;
        #1;
        chk("async_buf_cnt", 64'(buf_cnt), 64'd0);
        chk("async_d_ready", 64'(d_ready), 64'd1);
        chk("async_a_valid", 64'(i_set1.o_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // independent pair
        a = mk(32'd10, 5'd3, 1'b1, 5'd0, 5'd0, 4'd0, 4'd0);
        b = mk(32'd11, 5'd0, 1'b0, 5'd4, 5'd5, 4'd0, 4'd0);
        step(a, b, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("ind_a_valid", 64'(i_set1.o_valid), 64'd1);
        chk("ind_b_valid", 64'(i_set2.o_valid), 64'd1);
        chk("ind_issue",   64'(issue_cnt), 64'd2);
        chk("ind_b_pc",    64'(i_set2.pc), 64'd11);
        idle(1'b0);
        chk("ind_drained", 64'(buf_cnt), 64'd0);

        // RAW pair issues serially
        a = mk(32'd20, 5'd7, 1'b1, 5'd0, 5'd0, 4'd0, 4'd0);
        b = mk(32'd21, 5'd0, 1'b0, 5'd1, 5'd7, 4'd0, 4'd0);
        step(a, b, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("raw_a_valid", 64'(i_set1.o_valid), 64'd1);
        chk("raw_b_valid", 64'(i_set2.o_valid), 64'd0);
        chk("raw_issue1",  64'(issue_cnt), 64'd1);
        idle(1'b0);
        chk("raw_b_in_a",  64'(i_set1.pc), 64'd21);
        chk("raw_issue2",  64'(issue_cnt), 64'd1);

        // rd=0 writer never creates a hazard
        a = mk(32'd22, 5'd0, 1'b1, 5'd0, 5'd0, 4'd0, 4'd0);
        b = mk(32'd23, 5'd0, 1'b0, 5'd0, 5'd0, 4'd0, 4'd0);
        step(a, b, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("rd0_issue", 64'(issue_cnt), 64'd2);

        // two memory ops, then branch followed by add
        a = mk(32'd30, 5'd1, 1'b1, 5'd2, 5'd2, 4'h8, 4'd0);
        b = mk(32'd31, 5'd4, 1'b1, 5'd5, 5'd6, 4'h9, 4'd0);
        step(a, b, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("ld_issue1", 64'(issue_cnt), 64'd1);
        idle(1'b0);
        chk("ld_issue2", 64'(issue_cnt), 64'd1);
        chk("ld_pc2",    64'(i_set1.pc), 64'd31);
        a = mk(32'd40, 5'd0, 1'b0, 5'd1, 5'd2, 4'd0, 4'h1);
        b = mk(32'd41, 5'd3, 1'b1, 5'd4, 5'd5, 4'd0, 4'd0);
        step(a, b, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("br_issue1",  64'(issue_cnt), 64'd1);
        chk("br_b_valid", 64'(i_set2.o_valid), 64'd0);
        idle(1'b0);
        chk("br_issue2",  64'(issue_cnt), 64'd1);
        chk("br_add_pc",  64'(i_set1.pc), 64'd41);

        // realign head to 0, then fill to DEPTH under stall
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(ind(32'd100), ind(32'd101), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd102), ind(32'd103), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd104), ind(32'd105), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd106), ind(32'd107), 1'b1, 1'b1, 1'b1, 1'b0);
        chk("fill_rdy6", 64'(d_ready), 64'd1);
        step(ind(32'd108), ind(32'd109), 1'b1, 1'b1, 1'b1, 1'b0);
        chk("full_cnt",   64'(buf_cnt), 64'd8);
        chk("full_rdy",   64'(d_ready), 64'd0);
        chk("stall_iss",  64'(issue_cnt), 64'd0);
        step(ind(32'd108), ind(32'd109), 1'b1, 1'b1, 1'b1, 1'b0);
        chk("full_hold",  64'(buf_cnt), 64'd8);
        idle(1'b0);
        chk("drain_pc0",  64'(i_set1.pc), 64'd100);
        chk("drain_iss",  64'(issue_cnt), 64'd2);
        repeat (3) idle(1'b0);
        chk("drain_pc6",  64'(i_set1.pc), 64'd106);
        chk("drain_pc7",  64'(i_set2.pc), 64'd107);
        idle(1'b0);
        chk("drained",    64'(buf_cnt), 64'd0);

        // head at 1, fill to 7, then pair index 7 with index 0
        step(ind(32'd200), '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        step(ind(32'd201), ind(32'd202), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd203), ind(32'd204), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd205), ind(32'd206), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd207), '0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        chk("cnt7",       64'(buf_cnt), 64'd7);
        chk("cnt7_rdy",   64'(d_ready), 64'd0);
        idle(1'b0);
        step(ind(32'd208), '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mix_rdy",    64'(d_ready), 64'd1);
        idle(1'b0);
        idle(1'b0);
        chk("wrap_a_pc",  64'(i_set1.pc), 64'd207);
        chk("wrap_b_pc",  64'(i_set2.pc), 64'd208);
        chk("wrap_iss",   64'(issue_cnt), 64'd2);
        idle(1'b0);

        // flush beats stall and enqueue
        step(ind(32'd300), ind(32'd301), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd302), ind(32'd303), 1'b1, 1'b1, 1'b1, 1'b0);
        step(ind(32'd304), ind(32'd305), 1'b1, 1'b1, 1'b1, 1'b1);
        chk("fl_pre_cnt", 64'(buf_cnt), 64'd4);
        chk("fl_issue",   64'(issue_cnt), 64'd0);
        idle(1'b0);
        chk("fl_cnt",     64'(buf_cnt), 64'd0);
        chk("fl_a_valid", 64'(i_set1.o_valid), 64'd0);
        chk("fl_b_valid", 64'(i_set2.o_valid), 64'd0);
        step(ind(32'd306), '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("fl_after_pc", 64'(i_set1.pc), 64'd306);
        chk("fl_after_cnt", 64'(buf_cnt), 64'd1);
        idle(1'b0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
